frame_load_ctrl: RTL and testbench
==================================

# frame_load_ctrl

Sequencer for the 19-byte shift-in frame buffer (`data_ram`). It accepts a valid/ready byte stream, waits for a sync byte, and drives the buffer's `wen`/`din` for exactly `NBYTES` payload bytes. It then presents a frame-valid flag until the consumer acknowledges, with timeout abort and an optional checksum check. It sits between the byte receiver and the frame consumer that reads the buffer's parallel `dout`.

## Interface
- `NBYTES`, 19, payload bytes per frame; must equal the buffer depth.
- `SYNC`, 8'hA5, frame start marker; not written to the buffer.
- `TIMEOUT`, 255, maximum idle cycles between accepted payload bytes; range 1..255.
- `clk`  in  1  single clock; all logic is posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  upstream byte.
- `in_ready`  out  1  block accepts a byte this cycle.
- `ram_wen`  out  1  buffer shift enable; combinational.
- `ram_din`  out  8  buffer data; equals `in_data`.
- `frame_valid`  out  1  full frame is in the buffer; registered.
- `frame_err`  out  1  checksum mismatch; valid only while `frame_valid` is high.
- `frame_ack`  in  1  consumer has read `dout`.
- `timeout`  out  1  one-cycle pulse when a partial frame is aborted.
- `byte_cnt`  out  5  payload bytes accepted in the current frame.

## Operation
- A handshake occurs when `in_valid & in_ready` is high at a rising edge.
- States: IDLE, LOAD, HOLD. Reset enters IDLE.
- IDLE: `in_ready`=1 and `ram_wen`=0. A handshake with `in_data==SYNC` moves to LOAD. Any other byte is consumed and dropped.
- LOAD: `in_ready`=1 and `ram_wen`=`in_valid`. Each handshake increments `byte_cnt` and clears the idle counter.
  - A SYNC value received in LOAD is payload. There is no resync.
  - The handshake that brings `byte_cnt` to `NBYTES` moves to HOLD and sets `frame_valid`.
  - If the idle counter reaches `TIMEOUT` with no handshake, the block returns to IDLE and pulses `timeout`. The partial buffer contents are left in place and never flagged valid.
- HOLD: `in_ready`=0, `ram_wen`=0, `frame_valid`=1, and the buffer is frozen. `frame_ack` moves to IDLE, clears `frame_valid`, and zeroes `byte_cnt`. `frame_ack` is ignored outside HOLD.
- Buffer ordering: the first payload byte ends at `dout[7:0]` and the last at the top byte.

## Timing
- Reset values: `frame_valid`=0, `frame_err`=0, `timeout`=0, `byte_cnt`=0, and state is IDLE. With state IDLE, `in_ready` is 1 and `ram_wen` is 0.
- `ram_wen` and the handshake are in the same cycle, so the buffer shifts on the same edge the byte is accepted.
- `frame_valid` rises on the edge of the 19th payload handshake. The buffer holds the complete frame from that edge. Latency from the last byte to valid is 0 cycles after the edge.
- Ack to IDLE takes 1 edge. A new SYNC can be accepted in the cycle after `frame_valid` falls.
- If timeout and a handshake coincide in the same cycle, the handshake wins: the counter clears and there is no abort.
- Reset asserted mid-LOAD or mid-HOLD returns the block to IDLE immediately. Buffer contents are not this block's concern; the buffer has its own reset.
- The idle counter is 8 bits. It saturates and never wraps.

## Configuration
- Macro: `FRAME_LOAD_CHECKSUM_EN`.
- Defined: byte `NBYTES`-1 is the XOR of payload bytes 0..`NBYTES`-2. A running XOR is cleared on SYNC acceptance. `frame_err` is registered on the final handshake edge as (running XOR != last byte) and cleared on ack.
- Undefined: the checksum logic is absent and `frame_err` is tied to 0.

## Structure
- Shared package/header `frame_pkg`: state encodings (IDLE=2'd0, LOAD=2'd1, HOLD=2'd2), default `SYNC`, `NBYTES`, and the `byte_cnt` width.
- One sub-module, `frame_xor_acc`: clear/enable/data in, 8-bit accumulator out. It is instantiated only under `FRAME_LOAD_CHECKSUM_EN`.

## Test plan
- SYNC followed by bytes 0x01..0x13 back-to-back -> 19 `ram_wen` pulses, `frame_valid` high on the 19th edge, `dout[7:0]`=0x01, top byte=0x13, `in_ready`=0 while held.
- Bytes 0x00, 0x33, then SYNC -> the first two bytes are dropped with no `ram_wen`, and loading starts after SYNC.
- SYNC, 5 bytes, then 255 idle cycles -> `timeout` pulses once, the block returns to IDLE, and `frame_valid` stays 0. The same run with a byte arriving on cycle 255 -> no abort.
- Full frame, `frame_ack` held low for 10 cycles while `in_valid`=1 -> no shifts and `frame_valid` stays 1. Ack -> IDLE next edge with `byte_cnt`=0.
- With `FRAME_LOAD_CHECKSUM_EN`: 18 bytes 0x01 followed by 0x00 -> `frame_err`=0. The same with last byte 0x01 -> `frame_err`=1.
- `rst_n` pulsed low at byte 10 of LOAD -> all outputs at reset values. A following full frame loads normally.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared definitions for the frame buffer load sequencer: FSM encoding and frame geometry.
package frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int         FRAME_NBYTES  = 19;
    localparam logic [7:0] FRAME_SYNC    = 8'hA5;
    localparam int         FRAME_TIMEOUT = 255;
    localparam int         FRAME_DATA_W  = 8;
    localparam int         CNT_W         = 5;
    localparam int         IDLE_W        = 8;

endpackage

// File: rtl/frame_xor_acc.sv
// Running XOR accumulator over accepted payload bytes; clear takes priority over enable.
module frame_xor_acc
    import frame_pkg::*;
#(
    parameter int DATA_W = FRAME_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] acc
);

    // Data path only: always cleared on sync acceptance before it is read.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/frame_load_ctrl.sv
// Load sequencer for the shift-in frame buffer: sync hunt, payload load, hold until ack.
// Defining FRAME_LOAD_CHECKSUM_EN adds the trailing-XOR checksum check on frame_err.
module frame_load_ctrl
    import frame_pkg::*;
#(
    parameter int         NBYTES  = FRAME_NBYTES,
    parameter logic [7:0] SYNC    = FRAME_SYNC,
    parameter int         TIMEOUT = FRAME_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             ram_wen,
    output logic [7:0]       ram_din,
    output logic             frame_valid,
    output logic             frame_err,
    input  logic             frame_ack,
    output logic             timeout,
    output logic [CNT_W-1:0] byte_cnt
);

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NBYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [IDLE_W-1:0] idle_q;
    logic              sync_hit;
    logic              load_hs;
    logic              last_hs;
    logic              abort;
    logic              ack_hit;

    assign ram_din = in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        ram_wen  = 1'b0;
        sync_hit = 1'b0;
        load_hs  = 1'b0;
        last_hs  = 1'b0;
        abort    = 1'b0;
        ack_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && (in_data == SYNC)) begin
                    sync_hit = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                ram_wen  = in_valid;
                // A handshake in the same cycle as the limit always beats the abort.
                if (in_valid) begin
                    load_hs = 1'b1;
                    if (byte_cnt == LAST_CNT) begin
                        last_hs = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (idle_q >= IDLE_LIM) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (frame_ack) begin
                    ack_hit = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            idle_q      <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= abort;

            if (sync_hit || abort || ack_hit) begin
                byte_cnt <= '0;
            end else if (load_hs) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end

            // Idle counter only runs in LOAD and saturates rather than wrapping.
            if (sync_hit || load_hs || abort) begin
                idle_q <= '0;
            end else if ((state_q == ST_LOAD) && (idle_q != '1)) begin
                idle_q <= idle_q + IDLE_W'(1);
            end

            if (last_hs) begin
                frame_valid <= 1'b1;
            end else if (ack_hit) begin
                frame_valid <= 1'b0;
            end
        end
    end

`ifdef FRAME_LOAD_CHECKSUM_EN
    logic [7:0] xor_acc;

    frame_xor_acc #(
        .DATA_W (8)
    ) u_xor_acc (
        .clk (clk),
        .clr (sync_hit),
        .en  (load_hs),
        .din (in_data),
        .acc (xor_acc)
    );

    // On the final handshake the accumulator holds the XOR of every byte but the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (last_hs) begin
            frame_err <= (xor_acc != in_data);
        end else if (ack_hit) begin
            frame_err <= 1'b0;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Self-checking bench for frame_load_ctrl with a queue-based frame model and a shift-buffer stand-in.
module tb_frame_load_ctrl;
    import frame_pkg::*;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         NB   = 19;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       frame_ack = 1'b0;
    logic       in_ready;
    logic       ram_wen;
    logic [7:0] ram_din;
    logic       frame_valid;
    logic       frame_err;
    logic       timeout;
    logic [4:0] byte_cnt;

    logic [NB*8-1:0] ram_buf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the sequencer should have done, in frame-level terms.
    bit         m_loading;
    bit         m_held;
    bit         m_err;
    bit         m_tpulse;
    int         m_idle;
    logic [7:0] m_q[$];

    always #5 clk = ~clk;

    frame_load_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ram_wen     (ram_wen),
        .ram_din     (ram_din),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .frame_ack   (frame_ack),
        .timeout     (timeout),
        .byte_cnt    (byte_cnt)
    );

    // Stand-in for data_ram: new bytes enter at the top and shift toward dout[7:0].
    always_ff @(posedge clk) begin
        if (ram_wen) ram_buf <= {ram_din, ram_buf[NB*8-1:8]};
    end

    task automatic model_clear();
        m_loading = 1'b0;
        m_held    = 1'b0;
        m_err     = 1'b0;
        m_tpulse  = 1'b0;
        m_idle    = 0;
        m_q.delete();
    endtask

    // Advance one clock and apply the frame rules to the inputs seen at that edge.
    task automatic tick();
        logic [7:0] x;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            m_tpulse = 1'b0;
            if (m_held) begin
                if (frame_ack) begin
                    m_held = 1'b0;
                    m_err  = 1'b0;
                    m_q.delete();
                end
            end else if (!m_loading) begin
                if (in_valid && in_data == SYNC) begin
                    m_loading = 1'b1;
                    m_idle    = 0;
                    m_q.delete();
                end
            end else if (in_valid) begin
                m_q.push_back(in_data);
                m_idle = 0;
                if (m_q.size() == NB) begin
                    m_loading = 1'b0;
                    m_held    = 1'b1;
`ifdef FRAME_LOAD_CHECKSUM_EN
                    x = 8'h00;
                    for (int i = 0; i < NB - 1; i++) x = x ^ m_q[i];
                    m_err = (x != m_q[NB-1]);
`endif
                end
            end else begin
                m_idle++;
                if (m_idle >= 255) begin
                    m_loading = 1'b0;
                    m_tpulse  = 1'b1;
                    m_q.delete();
                end
            end
        end
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        frame_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        n_checks++; if (in_ready !== 1'b1)    begin n_errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_checks++; if (ram_wen !== 1'b0)     begin n_errors++; $display("FAIL reset_wen: got %b want 0", ram_wen); end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        n_checks++; if (frame_err !== 1'b0)   begin n_errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
        n_checks++; if (timeout !== 1'b0)     begin n_errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        n_checks++; if (byte_cnt !== 5'd0)    begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", byte_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_seq_frame();
        int wens = 0;
        in_valid = 1'b1;
        in_data  = SYNC;
        #2;
        n_checks++; if (ram_wen !== 1'b0) begin n_errors++; $display("FAIL sync_no_wen: got %b want 0", ram_wen); end
        tick();
        for (int b = 1; b <= NB; b++) begin
            in_data = 8'(b);
            #2;
            if (ram_wen === 1'b1 && in_ready === 1'b1) wens++;
            tick();
        end
        in_valid = 1'b0;
        #2;
        n_checks++; if (wens != NB)               begin n_errors++; $display("FAIL seq_wen_pulses: got %0d want %0d", wens, NB); end
        n_checks++; if (frame_valid !== 1'b1)     begin n_errors++; $display("FAIL seq_valid: got %b want 1", frame_valid); end
        n_checks++; if (byte_cnt !== 5'd19)       begin n_errors++; $display("FAIL seq_cnt: got %0d want 19", byte_cnt); end
        n_checks++; if (in_ready !== 1'b0)        begin n_errors++; $display("FAIL seq_ready_held: got %b want 0", in_ready); end
        n_checks++; if (ram_buf[7:0] !== 8'h01)   begin n_errors++; $display("FAIL seq_dout_low: got %h want 01", ram_buf[7:0]); end
        n_checks++; if (ram_buf[NB*8-1 -: 8] !== 8'h13) begin n_errors++; $display("FAIL seq_dout_top: got %h want 13", ram_buf[NB*8-1 -: 8]); end
        n_checks++; if (frame_err !== m_err)      begin n_errors++; $display("FAIL seq_err: got %b want %b", frame_err, m_err); end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic test_drop_then_sync();
        logic [7:0] junk [2];
        junk[0] = 8'h00;
        junk[1] = 8'h33;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = junk[i];
            #2;
            n_checks++; if (ram_wen !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL drop_byte%0d: wen %b ready %b want 0 1", i, ram_wen, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        #2;
        n_checks++; if (byte_cnt !== 5'd0) begin n_errors++; $display("FAIL drop_cnt: got %0d want 0", byte_cnt); end
        send(SYNC);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #2;
        n_checks++; if (ram_wen !== 1'b1) begin n_errors++; $display("FAIL drop_load_wen: got %b want 1", ram_wen); end
        tick();
        in_valid = 1'b0;
        #2;
        n_checks++; if (byte_cnt !== 5'd1) begin n_errors++; $display("FAIL drop_load_cnt: got %0d want 1", byte_cnt); end
        for (int i = 1; i < NB; i++) send(8'($urandom));
        #2;
        n_checks++; if (frame_valid !== 1'b1 || ram_buf[7:0] !== 8'h5A) begin n_errors++; $display("FAIL drop_frame: valid %b low %h want 1 5a", frame_valid, ram_buf[7:0]); end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic test_hold();
        logic [NB*8-1:0] snap;
        send(SYNC);
        for (int i = 0; i < NB; i++) send(8'($urandom));
        snap = ram_buf;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = (c == 3) ? SYNC : 8'($urandom);
            #2;
            n_checks++; if (ram_wen !== 1'b0 || frame_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_errors++; $display("FAIL hold_c%0d: wen %b valid %b ready %b want 0 1 0", c, ram_wen, frame_valid, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        #2;
        n_checks++; if (ram_buf !== snap) begin n_errors++; $display("FAIL hold_frozen: got %h want %h", ram_buf, snap); end
        for (int i = 0; i < NB; i++) begin
            n_checks++; if (ram_buf[i*8 +: 8] !== m_q[i]) begin n_errors++; $display("FAIL hold_byte%0d: got %h want %h", i, ram_buf[i*8 +: 8], m_q[i]); end
        end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        #2;
        n_checks++; if (frame_valid !== 1'b0 || byte_cnt !== 5'd0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL ack_idle: valid %b cnt %0d ready %b want 0 0 1", frame_valid, byte_cnt, in_ready);
        end
        send(SYNC);
        in_valid = 1'b1;
        in_data  = 8'h01;
        #2;
        n_checks++; if (ram_wen !== 1'b1) begin n_errors++; $display("FAIL resync_after_ack: got %b want 1", ram_wen); end
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < NB; i++) send(8'($urandom));
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int pulse_at = -1;
        send(SYNC);
        for (int i = 0; i < 5; i++) send(8'($urandom));
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (timeout === 1'b1) begin pulses++; pulse_at = i; end
            n_checks++; if (timeout !== m_tpulse || frame_valid !== 1'b0) begin
                n_errors++; $display("FAIL to_cycle%0d: timeout %b valid %b want %b 0", i, timeout, frame_valid, m_tpulse);
            end
        end
        n_checks++; if (pulses != 1 || pulse_at != 255) begin n_errors++; $display("FAIL to_pulse: count %0d at %0d want 1 at 255", pulses, pulse_at); end
        in_valid = 1'b1;
        in_data  = 8'h11;
        #2;
        n_checks++; if (ram_wen !== 1'b0) begin n_errors++; $display("FAIL to_back_idle: got %b want 0", ram_wen); end
        tick();
        in_valid = 1'b0;

        pulses = 0;
        send(SYNC);
        for (int i = 0; i < 5; i++) send(8'($urandom));
        for (int i = 1; i <= 254; i++) begin
            tick();
            if (timeout === 1'b1) pulses++;
        end
        in_valid = 1'b1;
        in_data  = 8'h77;
        #2;
        n_checks++; if (ram_wen !== 1'b1) begin n_errors++; $display("FAIL noabort_wen: got %b want 1", ram_wen); end
        tick();
        in_valid = 1'b0;
        #2;
        if (timeout === 1'b1) pulses++;
        n_checks++; if (pulses != 0 || byte_cnt !== 5'd6) begin n_errors++; $display("FAIL noabort: pulses %0d cnt %0d want 0 6", pulses, byte_cnt); end
    endtask

    task automatic test_reset_mid_load();
        rst_n = 1'b0;
        #1;
        model_clear();
        rst_n = 1'b1;
        tick();
        send(SYNC);
        for (int i = 1; i <= 9; i++) send(8'(i));
        in_valid = 1'b1;
        in_data  = 8'd10;
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        n_checks++; if (in_ready !== 1'b1 || ram_wen !== 1'b0 || frame_valid !== 1'b0 || frame_err !== 1'b0 || timeout !== 1'b0 || byte_cnt !== 5'd0) begin
            n_errors++; $display("FAIL midload_reset: ready %b wen %b valid %b err %b to %b cnt %0d want 1 0 0 0 0 0",
                                 in_ready, ram_wen, frame_valid, frame_err, timeout, byte_cnt);
        end
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        send(SYNC);
        for (int i = 0; i < NB; i++) send(8'($urandom));
        #2;
        n_checks++; if (frame_valid !== 1'b1 || byte_cnt !== 5'd19) begin n_errors++; $display("FAIL post_reset_frame: valid %b cnt %0d want 1 19", frame_valid, byte_cnt); end
        for (int i = 0; i < NB; i++) begin
            n_checks++; if (ram_buf[i*8 +: 8] !== m_q[i]) begin n_errors++; $display("FAIL post_reset_byte%0d: got %h want %h", i, ram_buf[i*8 +: 8], m_q[i]); end
        end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic test_checksum();
        logic [7:0] last [2];
        logic       want [2];
        last[0] = 8'h00;
        last[1] = 8'h01;
`ifdef FRAME_LOAD_CHECKSUM_EN
        want[0] = 1'b0;
        want[1] = 1'b1;
`else
        want[0] = 1'b0;
        want[1] = 1'b0;
`endif
        for (int k = 0; k < 2; k++) begin
            send(SYNC);
            for (int i = 0; i < NB - 1; i++) send(8'h01);
            send(last[k]);
            #2;
            n_checks++; if (frame_valid !== 1'b1 || frame_err !== want[k]) begin
                n_errors++; $display("FAIL checksum%0d: valid %b err %b want 1 %b", k, frame_valid, frame_err, want[k]);
            end
            frame_ack = 1'b1;
            tick();
            frame_ack = 1'b0;
            #2;
            n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL checksum%0d_clr: got %b want 0", k, frame_err); end
        end
    endtask

    task automatic test_random();
        bit prev_held = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
            frame_ack = m_held ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            #2;
            n_checks++;
            if (in_ready !== !m_held || ram_wen !== (m_loading && in_valid) || frame_valid !== m_held ||
                byte_cnt !== 5'(m_q.size()) || frame_err !== m_err || timeout !== m_tpulse) begin
                n_errors++;
                $display("FAIL rand_c%0d: ready %b wen %b valid %b cnt %0d err %b to %b want %b %b %b %0d %b %b",
                         c, in_ready, ram_wen, frame_valid, byte_cnt, frame_err, timeout,
                         !m_held, m_loading && in_valid, m_held, m_q.size(), m_err, m_tpulse);
            end
            if (m_held && !prev_held) begin
                for (int i = 0; i < NB; i++) begin
                    n_checks++; if (ram_buf[i*8 +: 8] !== m_q[i]) begin n_errors++; $display("FAIL rand_buf%0d: got %h want %h", i, ram_buf[i*8 +: 8], m_q[i]); end
                end
            end
            prev_held = m_held;
            tick();
        end
        in_valid  = 1'b0;
        frame_ack = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_seq_frame();
        test_drop_then_sync();
        test_hold();
        test_timeout();
        test_reset_mid_load();
        test_checksum();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
